// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline front end.
//   PCSRC_*        : pcsource encodings driven by the decode stage
//   NOP_INST       : instruction word used for IF/ID bubbles
//   fetch_state_t  : fetch controller state encoding
//   word_align()   : clears bits [1:0] of an address
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [1:0]  PCSRC_SEQ = 2'b00;
    localparam logic [1:0]  PCSRC_BR  = 2'b01;
    localparam logic [1:0]  PCSRC_JMP = 2'b10;

    localparam logic [31:0] NOP_INST  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DRAIN = 2'b10
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : word-aligned fetch address, stable while req is pending
//   imem_ack   : instruction valid this cycle (slave -> master)
//   imem_rdata : fetched instruction word (slave -> master)
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/add32.sv
// ---------------------------------------------------------------------------
// add32
// 32-bit modulo adder (carry out discarded).
//   i_a, i_b : operands
//   o_sum    : (i_a + i_b) mod 2^32
// ---------------------------------------------------------------------------
module add32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register holding pc4, inst and a valid flag.
//   clk, rst  : clock, synchronous active-high reset
//   i_flush   : replace contents with a bubble (highest priority)
//   i_hold    : keep current contents
//   i_load    : capture i_pc4 / i_inst as a real instruction
//   i_pc4     : PC+4 of the instruction being loaded
//   i_inst    : instruction word being loaded
//   o_pc4     : registered PC+4
//   o_inst    : registered instruction
//   o_valid   : 1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_hold,
    input  logic        i_load,
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_inst,
    output logic [31:0] o_pc4,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_pc4   <= 32'h0000_0000;
            o_inst  <= NOP_INST;
            o_valid <= 1'b0;
        end else if (i_flush) begin
            o_pc4   <= 32'h0000_0000;
            o_inst  <= NOP_INST;
            o_valid <= 1'b0;
        end else if (i_hold) begin
            o_pc4   <= o_pc4;
            o_inst  <= o_inst;
            o_valid <= o_valid;
        end else if (i_load) begin
            o_pc4   <= i_pc4;
            o_inst  <= i_inst;
            o_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage plus IF/ID register. Owns the PC, fetches over a
// req/ack handshake and accepts branch/jump redirects resolved in ID (no
// delay slot: a taken redirect squashes the wrong-path fetch).
//   clk, rst   : clock, synchronous active-high reset
//   pcsource   : 00 seq, 01 branch (bpc), 10 jump (jpc), 11 as seq
//   bpc, jpc   : branch / jump targets from ID
//   stall      : hold PC and IF/ID
//   imem       : instruction memory bus (master side)
//   pc4, inst  : IF/ID contents
//   id_valid   : IF/ID holds a real instruction
//
// state | meaning
// FETCH | request outstanding at pc; ack may arrive in the same cycle
// HOLD  | fetched word parked in hold_buf while stalled; no request
// DRAIN | redirect taken before ack; finish old request, then go to pend_pc
// ---------------------------------------------------------------------------
module if_fetch_unit import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic        stall,
    if_fetch_unit_if.master imem,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        id_valid
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend_pc;
    logic [31:0]  r_hold_buf;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target;
    logic         w_redirect;
    logic         w_ifid_load;
    logic         w_ifid_flush;
    logic [31:0]  w_ifid_inst;

    add32 u_pc_add (
        .i_a   (r_pc),
        .i_b   (32'd4),
        .o_sum (w_pc_plus4)
    );

    // pcsource is only trusted when ID holds a real, non-stalled instruction.
    assign w_redirect = id_valid && !stall &&
                        ((pcsource == PCSRC_BR) || (pcsource == PCSRC_JMP));
    assign w_target   = (pcsource == PCSRC_JMP) ? jpc : bpc;

    assign imem.imem_req  = !rst && ((r_state == FETCH) || (r_state == DRAIN));
    assign imem.imem_addr = word_align(r_pc);

    always_comb begin
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_inst  = imem.imem_rdata;
        case (r_state)
            FETCH: begin
                if (w_redirect) begin
                    w_ifid_flush = 1'b1;
                end else if (!stall) begin
                    if (imem.imem_ack) begin
                        w_ifid_load = 1'b1;
                    end else begin
                        w_ifid_flush = 1'b1;
                    end
                end
            end
            HOLD: begin
                w_ifid_inst = r_hold_buf;
                if (w_redirect) begin
                    w_ifid_flush = 1'b1;
                end else if (!stall) begin
                    w_ifid_load = 1'b1;
                end
            end
            default: begin
                // DRAIN: keep IF/ID a bubble so no second redirect can arrive.
                w_ifid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_pend_pc  <= 32'h0000_0000;
            r_hold_buf <= NOP_INST;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_redirect) begin
                        if (imem.imem_ack) begin
                            r_pc <= w_target;
                        end else begin
                            // Address must stay stable until ack, so park the target.
                            r_pend_pc <= w_target;
                            r_state   <= DRAIN;
                        end
                    end else if (imem.imem_ack) begin
                        if (stall) begin
                            r_hold_buf <= imem.imem_rdata;
                            r_state    <= HOLD;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= FETCH;
                    end else if (!stall) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        r_pc    <= r_pend_pc;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_ifid_flush),
        .i_hold  (stall),
        .i_load  (w_ifid_load),
        .i_pc4   (w_pc_plus4),
        .i_inst  (w_ifid_inst),
        .o_pc4   (pc4),
        .o_inst  (inst),
        .o_valid (id_valid)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Bench for if_fetch_unit: directed scenarios plus a randomized run checked
// against a program-order model (which instruction address must appear in ID
// next), with a memory model that has configurable wait states.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic        stall;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        id_valid;

    int unsigned mem_ws = 0;
    logic [31:0] mem_cnt = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch_unit_if bus ();

    always #5 clk = ~clk;

    // Instruction word stored at each word address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return w ^ 32'h5A5A_F00F;
    endfunction

    assign bus.imem_ack   = bus.imem_req && (mem_cnt >= mem_ws);
    assign bus.imem_rdata = inst_of(bus.imem_addr);

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_ack) mem_cnt <= 32'h0;
        else                               mem_cnt <= mem_cnt + 32'h1;
    end

    if_fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pcsource (pcsource),
        .bpc      (bpc),
        .jpc      (jpc),
        .stall    (stall),
        .imem     (bus),
        .pc4      (pc4),
        .inst     (inst),
        .id_valid (id_valid)
    );

    // Leaves the bench at the first post-reset cycle (rst just released).
    task automatic do_reset(input int unsigned ws);
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; pcsource = 2'b00; bpc = 32'h0; jpc = 32'h0;
        mem_ws = ws;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_pc4(input logic [31:0] v, output bit found);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (id_valid === 1'b1 && pc4 === v) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; pcsource = 2'b00; bpc = 32'h0; jpc = 32'h0; mem_ws = 0;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b0) $display("FAIL reset_req_same_cycle: got %0b expected 0", bus.imem_req);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.imem_req, id_valid, pc4, inst} !== {1'b0, 1'b0, 32'h0, NOP})
            $display("FAIL reset_state: req=%0b valid=%0b pc4=%h inst=%h expected 0 0 %h %h",
                     bus.imem_req, id_valid, pc4, inst, 32'h0, NOP);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC)
            $display("FAIL reset_first_fetch: req=%0b addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset(0);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            n_checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k))
                $display("FAIL seq_addr%0d: req=%0b addr=%h expected 1 %h", k, bus.imem_req, bus.imem_addr, 32'(4 * k));
            else n_pass++;
            n_checks++;
            if (k == 0) begin
                if (id_valid !== 1'b0) $display("FAIL seq_first_valid: got %0b expected 0", id_valid);
                else n_pass++;
            end else begin
                if ({id_valid, pc4, inst} !== {1'b1, 32'(4 * k), inst_of(32'(4 * (k - 1)))})
                    $display("FAIL seq_id%0d: valid=%0b pc4=%h inst=%h expected 1 %h %h", k,
                             id_valid, pc4, inst, 32'(4 * k), inst_of(32'(4 * (k - 1))));
                else n_pass++;
            end
        end
    endtask

    // Redirect from ID when the instruction at src_pc is there; one bubble expected.
    task automatic test_redirect(input logic [1:0] src, input logic [31:0] tgt, input int at_k);
        do_reset(0);
        repeat (at_k) @(negedge clk);
        pcsource = src;
        if (src == 2'b01) bpc = tgt; else jpc = tgt;
        @(negedge clk);
        pcsource = 2'b00;
        n_checks++;
        if ({id_valid, inst, bus.imem_addr} !== {1'b0, NOP, tgt})
            $display("FAIL redir%0d_bubble: valid=%0b inst=%h addr=%h expected 0 %h %h",
                     src, id_valid, inst, bus.imem_addr, NOP, tgt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({id_valid, pc4, inst} !== {1'b1, tgt + 32'd4, inst_of(tgt)})
            $display("FAIL redir%0d_target: valid=%0b pc4=%h inst=%h expected 1 %h %h",
                     src, id_valid, pc4, inst, tgt + 32'd4, inst_of(tgt));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({id_valid, pc4} !== {1'b1, tgt + 32'd8})
            $display("FAIL redir%0d_follow: valid=%0b pc4=%h expected 1 %h", src, id_valid, pc4, tgt + 32'd8);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset(0);
        repeat (2) @(negedge clk);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.imem_req, id_valid, pc4, inst} !== {1'b0, 1'b1, 32'h8, inst_of(32'h4)})
                $display("FAIL stall_hold%0d: req=%0b valid=%0b pc4=%h inst=%h expected 0 1 %h %h", c,
                         bus.imem_req, id_valid, pc4, inst, 32'h8, inst_of(32'h4));
            else n_pass++;
            if (c == 2) stall = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({id_valid, pc4, inst} !== {1'b1, 32'hC, inst_of(32'h8)})
            $display("FAIL stall_release: valid=%0b pc4=%h inst=%h expected 1 %h %h",
                     id_valid, pc4, inst, 32'hC, inst_of(32'h8));
        else n_pass++;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC)
            $display("FAIL stall_no_refetch: req=%0b addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, 32'hC);
        else n_pass++;
    endtask

    task automatic test_wait_redirect();
        bit found;
        bit acked;
        do_reset(2);
        wait_pc4(32'h10, found);
        n_checks++;
        if (!found || bus.imem_addr !== 32'h10 || bus.imem_ack !== 1'b0)
            $display("FAIL ws_reach: found=%0b addr=%h ack=%0b expected 1 %h 0", found, bus.imem_addr, bus.imem_ack, 32'h10);
        else n_pass++;
        pcsource = 2'b01; bpc = 32'h80;
        @(negedge clk);
        pcsource = 2'b00;
        acked = 1'b0;
        for (int i = 0; i < 10 && !acked; i++) begin
            n_checks++;
            if ({bus.imem_req, bus.imem_addr, id_valid} !== {1'b1, 32'h10, 1'b0})
                $display("FAIL ws_drain_addr: req=%0b addr=%h valid=%0b expected 1 %h 0",
                         bus.imem_req, bus.imem_addr, id_valid, 32'h10);
            else n_pass++;
            acked = bus.imem_ack;
            @(negedge clk);
        end
        n_checks++;
        if (!acked || bus.imem_addr !== 32'h80 || id_valid !== 1'b0)
            $display("FAIL ws_after_drain: acked=%0b addr=%h valid=%0b expected 1 %h 0", acked, bus.imem_addr, id_valid, 32'h80);
        else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (id_valid === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || pc4 !== 32'h84 || inst !== inst_of(32'h80))
            $display("FAIL ws_target: found=%0b pc4=%h inst=%h expected 1 %h %h", found, pc4, inst, 32'h84, inst_of(32'h80));
        else n_pass++;
    endtask

    task automatic test_reset_in_drain();
        bit found;
        do_reset(3);
        wait_pc4(32'h10, found);
        pcsource = 2'b01; bpc = 32'h80;
        @(negedge clk);
        pcsource = 2'b00;
        n_checks++;
        if (!found || {bus.imem_req, bus.imem_addr, id_valid} !== {1'b1, 32'h10, 1'b0})
            $display("FAIL rd_in_drain: found=%0b req=%0b addr=%h valid=%0b expected 1 1 %h 0",
                     found, bus.imem_req, bus.imem_addr, id_valid, 32'h10);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.imem_req, id_valid, inst} !== {1'b0, 1'b0, NOP})
            $display("FAIL rd_reset: req=%0b valid=%0b inst=%h expected 0 0 %h", bus.imem_req, id_valid, inst, NOP);
        else n_pass++;
        rst = 1'b0; mem_ws = 0;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC)
            $display("FAIL rd_resume_addr: req=%0b addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({id_valid, pc4, inst} !== {1'b1, RST_PC + 32'd4, inst_of(RST_PC)})
            $display("FAIL rd_resume_id: valid=%0b pc4=%h inst=%h expected 1 %h %h",
                     id_valid, pc4, inst, RST_PC + 32'd4, inst_of(RST_PC));
        else n_pass++;
    endtask

    task automatic test_wrap_and_align();
        do_reset(0);
        @(negedge clk);
        pcsource = 2'b10; jpc = 32'hFFFF_FFF8;
        @(negedge clk);
        pcsource = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({id_valid, pc4, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC})
            $display("FAIL wrap_pre: valid=%0b pc4=%h addr=%h expected 1 %h %h", id_valid, pc4, bus.imem_addr,
                     32'hFFFF_FFFC, 32'hFFFF_FFFC);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({id_valid, pc4, inst, bus.imem_addr} !== {1'b1, 32'h0, inst_of(32'hFFFF_FFFC), 32'h0})
            $display("FAIL wrap: valid=%0b pc4=%h inst=%h addr=%h expected 1 %h %h %h", id_valid, pc4, inst,
                     bus.imem_addr, 32'h0, inst_of(32'hFFFF_FFFC), 32'h0);
        else n_pass++;
        pcsource = 2'b01; bpc = 32'h203;
        @(negedge clk);
        pcsource = 2'b00;
        n_checks++;
        if (bus.imem_addr !== 32'h200 || id_valid !== 1'b0)
            $display("FAIL align_addr: addr=%h valid=%0b expected %h 0", bus.imem_addr, id_valid, 32'h200);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({id_valid, pc4, inst, bus.imem_addr} !== {1'b1, 32'h207, inst_of(32'h200), 32'h204})
            $display("FAIL align_id: valid=%0b pc4=%h inst=%h addr=%h expected 1 %h %h %h", id_valid, pc4, inst,
                     bus.imem_addr, 32'h207, inst_of(32'h200), 32'h204);
        else n_pass++;
    endtask

    // Random wait states, stalls and redirects; ID must show the program path.
    task automatic test_random();
        logic [31:0] exp_pc, prev_pc4, prev_inst, prev_addr;
        logic        prev_valid, prev_stall, prev_req, prev_ack;
        int          n_new, r;
        do_reset(0);
        exp_pc = RST_PC; n_new = 0;
        prev_valid = 1'b0; prev_stall = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        prev_pc4 = 32'h0; prev_inst = 32'h0; prev_addr = 32'h0;
        for (int c = 0; c < 1500; c++) begin
            if (c != 0) @(negedge clk);
            if (prev_ack) mem_ws = $urandom_range(0, 2);
            #1;
            if (prev_req && !prev_ack) begin
                n_checks++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr)
                    $display("FAIL rnd_handshake c%0d: req=%0b addr=%h expected 1 %h", c, bus.imem_req, bus.imem_addr, prev_addr);
                else n_pass++;
            end
            n_checks++;
            if (prev_valid && prev_stall) begin
                if ({id_valid, pc4, inst} !== {1'b1, prev_pc4, prev_inst})
                    $display("FAIL rnd_held c%0d: valid=%0b pc4=%h inst=%h expected 1 %h %h", c, id_valid, pc4, inst, prev_pc4, prev_inst);
                else n_pass++;
            end else if (id_valid === 1'b1) begin
                n_new++;
                if (pc4 !== exp_pc + 32'd4 || inst !== inst_of(exp_pc))
                    $display("FAIL rnd_order c%0d: pc4=%h inst=%h expected %h %h", c, pc4, inst, exp_pc + 32'd4, inst_of(exp_pc));
                else n_pass++;
            end else begin
                if (inst !== NOP) $display("FAIL rnd_bubble c%0d: inst=%h expected %h", c, inst, NOP);
                else n_pass++;
            end
            prev_valid = id_valid; prev_pc4 = pc4; prev_inst = inst;
            prev_req = bus.imem_req; prev_ack = bus.imem_ack; prev_addr = bus.imem_addr;
            stall = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            pcsource = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
            bpc = {20'h0, 12'($urandom)};
            jpc = {20'h0, 12'($urandom)};
            prev_stall = stall;
            if (id_valid === 1'b1 && !stall) begin
                if (pcsource == 2'b01)      exp_pc = bpc;
                else if (pcsource == 2'b10) exp_pc = jpc;
                else                        exp_pc = exp_pc + 32'd4;
            end
        end
        n_checks++;
        if (n_new < 150) $display("FAIL rnd_progress: got %0d instructions expected at least 150", n_new);
        else n_pass++;
        stall = 1'b0; pcsource = 2'b00;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pcsource = 2'b00; bpc = 32'h0; jpc = 32'h0;
        test_reset();
        test_sequential();
        test_redirect(2'b01, 32'h40, 3);
        test_redirect(2'b10, 32'h100, 2);
        test_stall();
        test_wait_redirect();
        test_reset_in_drain();
        test_wrap_and_align();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
